// File: rtl/mux_rr_arbiter.sv
// Eight-way round-robin arbiter that lets one requester hold the output for a burst.
// The winning 8-bit word is captured into a registered output stage with a valid/ready handshake.
module mux_rr_arbiter #(
  parameter int BURST = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] I0,
  input  logic [7:0] I1,
  input  logic [7:0] I2,
  input  logic [7:0] I3,
  input  logic [7:0] I4,
  input  logic [7:0] I5,
  input  logic [7:0] I6,
  input  logic [7:0] I7,
  input  logic [7:0] Req,
  input  logic       Ready,
  output logic [7:0] Grant,
  output logic [7:0] y,
  output logic [2:0] Sel,
  output logic       Valid
);

  localparam int DATA_W = 8;
  localparam logic [3:0] BURST_LIM = 4'(BURST);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        owner_q, owner_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [2:0]        sel_q, sel_d;
  logic              valid_q, valid_d;

  logic [DATA_W-1:0] word [8];
  logic              load;
  logic              cont;
  logic [2:0]        winner;

  assign word[0] = I0;
  assign word[1] = I1;
  assign word[2] = I2;
  assign word[3] = I3;
  assign word[4] = I4;
  assign word[5] = I5;
  assign word[6] = I6;
  assign word[7] = I7;

  // First requesting index at or after start, wrapping 7 -> 0.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] start);
    logic [2:0] idx;
    logic       found;
    rr_pick = start;
    found   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = start + 3'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    load   = (!valid_q || Ready) && (Req != 8'h00) && !Reset;
    cont   = (state_q == ST_BURST) && Req[owner_q] && (cnt_q < BURST_LIM);
    winner = cont ? owner_q : rr_pick(Req, ptr_q);
    Grant  = load ? (8'h01 << winner) : 8'h00;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    if (load) begin
      ptr_d   = winner + 3'd1;
      y_d     = word[winner];
      sel_d   = winner;
      valid_d = 1'b1;
      if (cont) begin
        cnt_d = cnt_q + 4'd1;
      end else begin
        owner_d = winner;
        cnt_d   = 4'd1;
        state_d = (BURST > 1) ? ST_BURST : ST_IDLE;
      end
    end else begin
      if (valid_q && Ready) valid_d = 1'b0;
      // Owner let go while nothing was loaded: its burst is over.
      if ((state_q == ST_BURST) && !Req[owner_q]) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 3'd0;
      owner_q <= 3'd0;
      cnt_q   <= 4'd0;
      y_q     <= '0;
      sel_q   <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign y     = y_q;
  assign Sel   = sel_q;
  assign Valid = valid_q;

endmodule
